// File: rtl/stereo_mixer_seq.sv
// Sequential stereo mixer: captures NUM_CH voices on a sample tick, accumulates one voice per
// cycle, then saturates and presents the left/right mix with a one-cycle valid strobe.
module stereo_mixer_seq #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned VOL_W          = 8,
    parameter int unsigned HEADROOM_SHIFT = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      sample_valid_in,
    input  logic [NUM_CH*WIDTH-1:0]   note_data_in,
    input  logic [NUM_CH*2-1:0]       stereo_data_in,
    input  logic [NUM_CH*VOL_W-1:0]   vol_in,
    input  logic                      stereo_on,
    output logic [WIDTH-1:0]          sample_l,
    output logic [WIDTH-1:0]          sample_r,
    output logic                      sample_valid_out,
    output logic                      busy_out,
    output logic                      overrun_out
);

    localparam int unsigned PW = WIDTH + VOL_W + 1;
    localparam int unsigned AW = WIDTH + VOL_W + 1 + $clog2(NUM_CH) + 1;
    localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SH = VOL_W + HEADROOM_SHIFT;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e                     state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic signed [AW-1:0]       acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [NUM_CH*WIDTH-1:0]    note_q;
    logic [NUM_CH*2-1:0]        route_q;
    logic [NUM_CH*VOL_W-1:0]    vol_q;
    logic                       stereo_q;
    logic                       capture;
    logic [WIDTH-1:0]           sample_l_q, sample_r_q;
    logic                       valid_q, overrun_q;

    logic [WIDTH-1:0]           note_sel;
    logic [VOL_W-1:0]           vol_sel;
    logic [1:0]                 route_sel;
    logic signed [PW-1:0]       prod;

    // Floor via arithmetic shift, then clamp into the signed output range.
    function automatic logic [WIDTH-1:0] saturate(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> SH;
        if (s > SAT_MAX) begin
            return SAT_MAX[WIDTH-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[WIDTH-1:0];
        end
        return s[WIDTH-1:0];
    endfunction

    always_comb begin
        note_sel  = '0;
        vol_sel   = '0;
        route_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (idx_q == IW'(i)) begin
                note_sel  = note_q[i*WIDTH +: WIDTH];
                vol_sel   = vol_q[i*VOL_W +: VOL_W];
                route_sel = route_q[i*2 +: 2];
            end
        end
    end

    assign prod = PW'($signed(note_sel)) * PW'($signed({1'b0, vol_sel}));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sample_valid_in) begin
                    capture = 1'b1;
                    acc_l_d = '0;
                    acc_r_d = '0;
                    idx_d   = '0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (route_sel[1] || !stereo_q) acc_l_d = acc_l_q + AW'(prod);
                if (route_sel[0] || !stereo_q) acc_r_d = acc_r_q + AW'(prod);
                if (idx_q == IW'(NUM_CH - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy_out = (state_q != StIdle);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            note_q     <= '0;
            route_q    <= '0;
            vol_q      <= '0;
            stereo_q   <= 1'b0;
            sample_l_q <= '0;
            sample_r_q <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            valid_q   <= (state_q == StDone);
            overrun_q <= overrun_q | (busy_out & sample_valid_in);
            if (capture) begin
                note_q   <= note_data_in;
                route_q  <= stereo_data_in;
                vol_q    <= vol_in;
                stereo_q <= stereo_on;
            end
            if (state_q == StDone) begin
                sample_l_q <= saturate(acc_l_q);
                sample_r_q <= saturate(acc_r_q);
            end
        end
    end

    assign sample_l         = sample_l_q;
    assign sample_r         = sample_r_q;
    assign sample_valid_out = valid_q;
    assign overrun_out      = overrun_q;

endmodule
